// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg                                                              |
// | 640x480@60 raster timing constants and the shared coordinate type.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vga_pkg;

    localparam int unsigned COORD_W   = 10;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned CLK_DIV   = 4;

    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

    // Inclusive range test used for the active-low sync windows.
    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_sync_if                                                          |
// | Raster coordinates, sync pulses and ticks fanned out to renderers.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface vga_sync_if;
    import vga_pkg::coord_t;

    coord_t x;
    coord_t y;
    logic   p_tick;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   frame_tick;

    modport master (
        output x, y, p_tick, hsync, vsync, video_on, frame_tick
    );

    modport slave (
        input  x, y, p_tick, hsync, vsync, video_on, frame_tick
    );

endinterface
`default_nettype wire

// File: rtl/vga_sync_pix_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pix_tick_gen                                                         |
// | Divides clk by CLK_DIV (>= 2) into a one-cycle pixel-enable pulse.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pix_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick_o
);

    localparam int unsigned           DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]      c_DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // >= rather than == so an out-of-range divider value recovers in one step.
    always_comb begin
        div_d = div_q + 1'b1;
        if (div_q >= c_DIV_MAX) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign p_tick_o = (div_q == c_DIV_MAX);

endmodule
`default_nettype wire

// File: rtl/vga_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_sync                                                             |
// | Horizontal/vertical raster counters, sync pulses and frame tick.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vga_sync #(
    parameter int unsigned H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_pkg::H_BACK,
    parameter int unsigned V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_pkg::V_BACK,
    parameter int unsigned CLK_DIV   = vga_pkg::CLK_DIV
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);

    typedef vga_pkg::coord_t coord_t;

    localparam int unsigned c_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned c_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t c_H_MAX      = coord_t'(c_H_TOTAL - 1);
    localparam coord_t c_V_MAX      = coord_t'(c_V_TOTAL - 1);
    localparam coord_t c_H_DISP     = coord_t'(H_DISPLAY);
    localparam coord_t c_V_DISP     = coord_t'(V_DISPLAY);
    localparam coord_t c_HS_START   = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t c_HS_END     = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t c_VS_START   = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t c_VS_END     = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   w_p_tick;
    coord_t h_q, h_d;
    coord_t v_q, v_d;
    logic   hs_q, hs_d;
    logic   vs_q, vs_d;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .p_tick_o (w_p_tick)
    );

    // Syncs are decoded from the next-state counters so they switch on
    // exactly the same edge as x/y.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (w_p_tick) begin
            if (h_q >= c_H_MAX) begin
                h_d = '0;
                if (v_q >= c_V_MAX) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        hs_d = !vga_pkg::in_range(h_d, c_HS_START, c_HS_END);
        vs_d = !vga_pkg::in_range(v_d, c_VS_START, c_VS_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign vga.x          = h_q;
    assign vga.y          = v_q;
    assign vga.p_tick     = w_p_tick;
    assign vga.hsync      = hs_q;
    assign vga.vsync      = vs_q;
    assign vga.video_on   = (h_q < c_H_DISP) && (v_q < c_V_DISP);
    assign vga.frame_tick = w_p_tick && (h_q == c_H_MAX) && (v_q == c_V_MAX);

endmodule
`default_nettype wire

// File: tb/tb_vga_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_sync                                                          |
// | Self-checking bench: default, CLK_DIV=2 and reduced-geometry DUTs.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vga_sync;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pt;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       ft;
    } exp_t;

    typedef struct {
        int unsigned d, hd, hf, hsw, hb, vd, vf, vsw, vb;
    } cfg_t;

    // Reduced geometry so whole frames fit in a short run: 23 x 17, div 3.
    localparam int unsigned C_HD = 16, C_HF = 2, C_HS = 3, C_HB = 2;
    localparam int unsigned C_VD = 10, C_VF = 2, C_VS = 2, C_VB = 3;
    localparam int unsigned C_DIV = 3;
    localparam int unsigned C_FRAME = (C_HD + C_HF + C_HS + C_HB) * (C_VD + C_VF + C_VS + C_VB) * C_DIV;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int unsigned ka, kb, kc;
    int n_checks = 0;
    int n_fail   = 0;
    cfg_t cfg_a, cfg_b, cfg_c;
    exp_t rst_v;

    vga_sync_if ifa ();
    vga_sync_if ifb ();
    vga_sync_if ifc ();

    vga_sync u_a (.clk(clk), .reset(rst_a), .vga(ifa));

    vga_sync #(.CLK_DIV(2)) u_b (.clk(clk), .reset(rst_b), .vga(ifb));

    vga_sync #(
        .H_DISPLAY(C_HD), .H_FRONT(C_HF), .H_SYNC(C_HS), .H_BACK(C_HB),
        .V_DISPLAY(C_VD), .V_FRONT(C_VF), .V_SYNC(C_VS), .V_BACK(C_VB),
        .CLK_DIV(C_DIV)
    ) u_c (.clk(clk), .reset(rst_c), .vga(ifc));

    always #5 clk = ~clk;

    // Clock edges seen since each DUT's reset was released.
    always @(posedge clk or posedge rst_a) if (rst_a) ka <= 0; else ka <= ka + 1;
    always @(posedge clk or posedge rst_b) if (rst_b) kb <= 0; else kb <= kb + 1;
    always @(posedge clk or posedge rst_c) if (rst_c) kc <= 0; else kc <= kc + 1;

    // Reference: position follows directly from elapsed clocks.
    function automatic exp_t model(input cfg_t c, input int unsigned k);
        int unsigned ht, vt, p, xx, yy;
        exp_t e;
        ht   = c.hd + c.hf + c.hsw + c.hb;
        vt   = c.vd + c.vf + c.vsw + c.vb;
        p    = k / c.d;
        xx   = p % ht;
        yy   = (p / ht) % vt;
        e.x  = xx[9:0];
        e.y  = yy[9:0];
        e.pt = ((k % c.d) == c.d - 1);
        e.hs = !(xx >= c.hd + c.hf && xx < c.hd + c.hf + c.hsw);
        e.vs = !(yy >= c.vd + c.vf && yy < c.vd + c.vf + c.vsw);
        e.vo = (xx < c.hd) && (yy < c.vd);
        e.ft = e.pt && (xx == ht - 1) && (yy == vt - 1);
        return e;
    endfunction

    function automatic exp_t obs_a();
        return {ifa.x, ifa.y, ifa.p_tick, ifa.hsync, ifa.vsync, ifa.video_on, ifa.frame_tick};
    endfunction
    function automatic exp_t obs_b();
        return {ifb.x, ifb.y, ifb.p_tick, ifb.hsync, ifb.vsync, ifb.video_on, ifb.frame_tick};
    endfunction
    function automatic exp_t obs_c();
        return {ifc.x, ifc.y, ifc.p_tick, ifc.hsync, ifc.vsync, ifc.video_on, ifc.frame_tick};
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("x=%0d y=%0d pt=%0b hs=%0b vs=%0b vo=%0b ft=%0b",
                         v.x, v.y, v.pt, v.hs, v.vs, v.vo, v.ft);
    endfunction

    task automatic test_reset();
        exp_t o, e;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        o = obs_a(); n_checks++;
        if (o !== rst_v) begin n_fail++; $display("FAIL reset_a: got %s want %s", fmt(o), fmt(rst_v)); end
        o = obs_b(); n_checks++;
        if (o !== rst_v) begin n_fail++; $display("FAIL reset_b: got %s want %s", fmt(o), fmt(rst_v)); end
        o = obs_c(); n_checks++;
        if (o !== rst_v) begin n_fail++; $display("FAIL reset_c: got %s want %s", fmt(o), fmt(rst_v)); end
        #1 rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (ifa.p_tick !== (i % 4 == 3) || ifa.x !== 10'(i / 4) || ifa.y !== 10'd0) begin
                n_fail++;
                $display("FAIL first_ticks clk%0d: got pt=%0b x=%0d y=%0d want pt=%0b x=%0d y=0",
                         i, ifa.p_tick, ifa.x, ifa.y, (i % 4 == 3), i / 4);
            end
            o = obs_b(); e = model(cfg_b, kb); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL start_b clk%0d: got %s want %s", i, fmt(o), fmt(e)); end
            o = obs_c(); e = model(cfg_c, kc); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL start_c clk%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_line();
        exp_t o, e;
        int first_low = -1;
        int low_px = 0;
        bit done = 1'b0;
        logic [9:0] px, py;
        px = ifa.x; py = ifa.y;
        for (int i = 0; i < 3400 && !done; i++) begin
            @(negedge clk);
            o = obs_a(); e = model(cfg_a, ka); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL line_a: got %s want %s", fmt(o), fmt(e)); end
            if (o.pt && !o.hs) begin
                low_px++;
                if (first_low < 0) first_low = int'(o.x);
            end
            if (o.pt && o.y == 10'd0 && (o.x == 10'd639 || o.x == 10'd640)) begin
                n_checks++;
                if (o.vo !== (o.x == 10'd639)) begin
                    n_fail++; $display("FAIL video_on_a (%0d,0): got %0b want %0b", o.x, o.vo, (o.x == 10'd639));
                end
            end
            if (px == 10'd799 && o.x == 10'd0) begin
                done = 1'b1; n_checks++;
                if (o.y !== py + 10'd1) begin n_fail++; $display("FAIL line_wrap_y: got %0d want %0d", o.y, py + 10'd1); end
            end
            px = o.x; py = o.y;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL line_wrap_timeout: got no wrap want wrap within 3400 clocks"); end
        n_checks++;
        if (low_px != 96) begin n_fail++; $display("FAIL hsync_width: got %0d want 96", low_px); end
        n_checks++;
        if (first_low != 656) begin n_fail++; $display("FAIL hsync_start: got %0d want 656", first_low); end
    endtask

    task automatic test_video_on();
        int unsigned pxs [4];
        int unsigned pys [4];
        bit          evo [4];
        bit          seen[4];
        pxs = '{C_HD - 1, C_HD, 0, 0};
        pys = '{C_VD - 1, 0, C_VD, 0};
        evo = '{1'b1, 1'b0, 1'b0, 1'b1};
        seen = '{1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 2 * C_FRAME + 10; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                if (!seen[j] && ifc.x == 10'(pxs[j]) && ifc.y == 10'(pys[j])) begin
                    seen[j] = 1'b1; n_checks++;
                    if (ifc.video_on !== evo[j]) begin
                        n_fail++; $display("FAIL video_on_c (%0d,%0d): got %0b want %0b", pxs[j], pys[j], ifc.video_on, evo[j]);
                    end
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (!seen[j]) begin n_fail++; $display("FAIL video_on_reach%0d: got unreached want reached", j); end
        end
    endtask

    task automatic test_frame();
        exp_t o, e;
        bit vs_low[32];
        int frames = 0;
        int last_ft = -1;
        bit expect_zero = 1'b0;
        foreach (vs_low[j]) vs_low[j] = 1'b0;
        for (int i = 0; i < 3 * C_FRAME + 50 && frames < 2; i++) begin
            @(negedge clk);
            o = obs_c(); e = model(cfg_c, kc); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL frame_c: got %s want %s", fmt(o), fmt(e)); end
            if (expect_zero) begin
                expect_zero = 1'b0; n_checks++;
                if (o.x !== 10'd0 || o.y !== 10'd0 || o.ft !== 1'b0) begin
                    n_fail++; $display("FAIL frame_wrap: got %s want x=0 y=0 ft=0", fmt(o));
                end
            end
            if (o.ft) begin
                frames++; expect_zero = 1'b1; n_checks++;
                if (o.x !== 10'd22 || o.y !== 10'd16) begin
                    n_fail++; $display("FAIL frame_tick_pos: got (%0d,%0d) want (22,16)", o.x, o.y);
                end
                if (last_ft >= 0) begin
                    n_checks++;
                    if (i - last_ft != int'(C_FRAME)) begin
                        n_fail++; $display("FAIL frame_period: got %0d want %0d", i - last_ft, C_FRAME);
                    end
                end
                last_ft = i;
            end
            if (!o.vs && o.y < 10'd32) vs_low[o.y[4:0]] = 1'b1;
        end
        n_checks++;
        if (frames != 2) begin n_fail++; $display("FAIL frame_tick_count: got %0d want 2", frames); end
        for (int yy = 0; yy < 17; yy++) begin
            n_checks++;
            if (vs_low[yy] !== (yy == 12 || yy == 13)) begin
                n_fail++; $display("FAIL vsync_line y=%0d: got low=%0b want low=%0b", yy, vs_low[yy], (yy == 12 || yy == 13));
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t o, e;
        bit hit = 1'b0;
        for (int i = 0; i < 1500 && !hit; i++) begin
            @(negedge clk);
            if (ifa.x == 10'd300) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL mid_reset_reach: got no x=300 want x=300 within 1500 clocks"); end
        #2 rst_a = 1'b1;
        #1 o = obs_a(); n_checks++;
        if (o !== rst_v) begin n_fail++; $display("FAIL mid_reset_async: got %s want %s", fmt(o), fmt(rst_v)); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = obs_a(); n_checks++;
        if (o !== rst_v) begin n_fail++; $display("FAIL mid_reset_hold: got %s want %s", fmt(o), fmt(rst_v)); end
        #1 rst_a = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (ifa.p_tick !== (i % 4 == 3) || ifa.x !== 10'(i / 4) || ifa.y !== 10'd0) begin
                n_fail++;
                $display("FAIL mid_reset_restart clk%0d: got pt=%0b x=%0d y=%0d want pt=%0b x=%0d y=0",
                         i, ifa.p_tick, ifa.x, ifa.y, (i % 4 == 3), i / 4);
            end
        end

        repeat ($urandom_range(100, 1000)) @(negedge clk);
        #2 rst_c = 1'b1;
        #1 o = obs_c(); n_checks++;
        if (o !== rst_v) begin n_fail++; $display("FAIL mid_reset_c_async: got %s want %s", fmt(o), fmt(rst_v)); end
        repeat ($urandom_range(1, 3)) @(posedge clk);
        @(negedge clk);
        #1 rst_c = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            o = obs_c(); e = model(cfg_c, kc); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL mid_reset_c_run: got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_clk_div2();
        exp_t o, e;
        int last_pt = -1;
        int last_wrap = -1;
        int lines = 0;
        int first_low = -1;
        int low_px = 0;
        logic [9:0] px;
        px = ifb.x;
        for (int i = 0; i < 3700 && lines < 2; i++) begin
            @(negedge clk);
            o = obs_b(); e = model(cfg_b, kb); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL div2_run: got %s want %s", fmt(o), fmt(e)); end
            if (o.pt) begin
                if (last_pt >= 0) begin
                    n_checks++;
                    if (i - last_pt != 2) begin n_fail++; $display("FAIL div2_tick_period: got %0d want 2", i - last_pt); end
                end
                last_pt = i;
            end
            if (px == 10'd799 && o.x == 10'd0) begin
                if (last_wrap >= 0) begin
                    n_checks++;
                    if (i - last_wrap != 1600) begin n_fail++; $display("FAIL div2_line_period: got %0d want 1600", i - last_wrap); end
                end
                last_wrap = i; lines++;
            end
            if (lines == 1 && o.pt && !o.hs) begin
                low_px++;
                if (first_low < 0) first_low = int'(o.x);
            end
            px = o.x;
        end
        n_checks++;
        if (lines != 2) begin n_fail++; $display("FAIL div2_lines: got %0d want 2", lines); end
        n_checks++;
        if (low_px != 96) begin n_fail++; $display("FAIL div2_hsync_width: got %0d want 96", low_px); end
        n_checks++;
        if (first_low != 656) begin n_fail++; $display("FAIL div2_hsync_start: got %0d want 656", first_low); end
    endtask

    initial begin
        cfg_a = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
        cfg_b = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
        cfg_c = '{C_DIV, C_HD, C_HF, C_HS, C_HB, C_VD, C_VF, C_VS, C_VB};
        rst_v = '{x: 10'd0, y: 10'd0, pt: 1'b0, hs: 1'b1, vs: 1'b1, vo: 1'b1, ft: 1'b0};
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        test_reset();
        test_line();
        test_video_on();
        test_frame();
        test_mid_reset();
        test_clk_div2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
